// File: rtl/debounce_nibble_counter.sv
// Two debounced push-buttons drive a 4-bit up/down counter.
// Each accepted press (stable 0->1) steps the nibble by one and pulses o_Count_Change.
module debounce_nibble_counter #(
    parameter int unsigned DEBOUNCE_LIMIT = 250000
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic       i_Switch_Up,
    input  logic       i_Switch_Down,
    output logic [3:0] o_Binary_Num,
    output logic       o_Count_Change
);

    localparam int unsigned CNT_W  = $clog2(DEBOUNCE_LIMIT);
    localparam int unsigned N_SW   = 2;
    localparam int unsigned SW_UP  = 0;
    localparam int unsigned SW_DN  = 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_LIMIT - 1);

    logic [N_SW-1:0]  r_sync1;
    logic [N_SW-1:0]  r_sync2;
    logic [N_SW-1:0]  r_stable;
    logic [CNT_W-1:0] r_cnt [N_SW];
    logic [N_SW-1:0]  w_raw;
    logic [N_SW-1:0]  w_accept;
    logic [N_SW-1:0]  w_press;

    assign w_raw = {i_Switch_Down, i_Switch_Up};

    // A level is accepted on the edge where the mismatch counter has saturated.
    always_comb begin
        w_accept = '0;
        w_press  = '0;
        for (int i = 0; i < N_SW; i++) begin
            w_accept[i] = (r_sync2[i] != r_stable[i]) && (r_cnt[i] == CNT_MAX);
            w_press[i]  = w_accept[i] && r_sync2[i];
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_sync1        <= '0;
            r_sync2        <= '0;
            r_stable       <= '0;
            for (int i = 0; i < N_SW; i++) begin
                r_cnt[i] <= '0;
            end
            o_Binary_Num   <= 4'd0;
            o_Count_Change <= 1'b0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            for (int i = 0; i < N_SW; i++) begin
                if (r_sync2[i] == r_stable[i]) begin
                    r_cnt[i] <= '0;
                end else if (w_accept[i]) begin
                    r_stable[i] <= r_sync2[i];
                    r_cnt[i]    <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
            // Simultaneous presses cancel; releases never count.
            o_Count_Change <= 1'b0;
            if (w_press[SW_UP] && !w_press[SW_DN]) begin
                o_Binary_Num   <= o_Binary_Num + 4'd1;
                o_Count_Change <= 1'b1;
            end else if (w_press[SW_DN] && !w_press[SW_UP]) begin
                o_Binary_Num   <= o_Binary_Num - 4'd1;
                o_Count_Change <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_debounce_nibble_counter.sv
// Directed bench for debounce_nibble_counter with DEBOUNCE_LIMIT=4.
module tb_debounce_nibble_counter;

    logic       clk;
    logic       rst;
    logic       sw_up;
    logic       sw_dn;
    logic [3:0] bin;
    logic       chg;

    int errors = 0;
    int checks = 0;

    debounce_nibble_counter #(.DEBOUNCE_LIMIT(4)) dut (
        .i_Clk          (clk),
        .i_Reset        (rst),
        .i_Switch_Up    (sw_up),
        .i_Switch_Down  (sw_dn),
        .o_Binary_Num   (bin),
        .o_Count_Change (chg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One rising edge, then settle before sampling or driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; sw_up = 1'b0; sw_dn = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    // Hold the given switches 6 edges, release 6 edges; count output pulses.
    task automatic press(input logic up, input logic dn, output int pulses);
        pulses = 0;
        sw_up = up; sw_dn = dn;
        for (int e = 0; e < 6; e++) begin
            tick();
            if (chg === 1'b1) pulses++;
        end
        sw_up = 1'b0; sw_dn = 1'b0;
        for (int e = 0; e < 6; e++) begin
            tick();
            if (chg === 1'b1) pulses++;
        end
    endtask

    task automatic test_reset();
        sw_up = 1'b1; sw_dn = 1'b1; rst = 1'b1;
        tick(); tick();
        checks++;
        if (bin !== 4'd0 || chg !== 1'b0) begin
            errors++;
            $display("FAIL reset: bin=%0d chg=%b, expected bin=0 chg=0", bin, chg);
        end
        sw_up = 1'b0; sw_dn = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_first_press();
        logic [3:0] exp_bin;
        logic       exp_chg;
        do_reset();
        sw_up = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            exp_bin = (e >= 6) ? 4'd1 : 4'd0;
            exp_chg = (e == 6);
            checks++;
            if (bin !== exp_bin || chg !== exp_chg) begin
                errors++;
                $display("FAIL first_press edge %0d: bin=%0d chg=%b, expected bin=%0d chg=%b",
                         e, bin, chg, exp_bin, exp_chg);
            end
        end
        sw_up = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            checks++;
            if (bin !== 4'd1 || chg !== 1'b0) begin
                errors++;
                $display("FAIL release edge %0d: bin=%0d chg=%b, expected bin=1 chg=0", e, bin, chg);
            end
        end
    endtask

    task automatic test_down_wrap();
        int p;
        do_reset();
        press(1'b0, 1'b1, p);
        checks++;
        if (bin !== 4'd15 || p !== 1) begin
            errors++;
            $display("FAIL down_wrap: bin=%0d pulses=%0d, expected bin=15 pulses=1", bin, p);
        end
    endtask

    task automatic test_up_wrap();
        int p;
        int total;
        logic [3:0] exp_bin;
        total = 0;
        do_reset();
        for (int n = 1; n <= 16; n++) begin
            press(1'b1, 1'b0, p);
            total += p;
            exp_bin = 4'(n);
            checks++;
            if (bin !== exp_bin) begin
                errors++;
                $display("FAIL up_wrap press %0d: bin=%0d, expected %0d", n, bin, exp_bin);
            end
        end
        checks++;
        if (total !== 16) begin
            errors++;
            $display("FAIL up_wrap pulses: got %0d, expected 16", total);
        end
    endtask

    task automatic test_glitch();
        int pulses;
        pulses = 0;
        do_reset();
        sw_up = 1'b1;
        for (int e = 0; e < 3; e++) begin
            tick();
            if (chg === 1'b1) pulses++;
        end
        sw_up = 1'b0;
        for (int e = 0; e < 10; e++) begin
            tick();
            if (chg === 1'b1) pulses++;
        end
        checks++;
        if (bin !== 4'd0 || pulses !== 0) begin
            errors++;
            $display("FAIL glitch: bin=%0d pulses=%0d, expected bin=0 pulses=0", bin, pulses);
        end
    endtask

    task automatic test_both();
        int p;
        int pulses;
        pulses = 0;
        do_reset();
        press(1'b1, 1'b1, pulses);
        checks++;
        if (bin !== 4'd0 || pulses !== 0) begin
            errors++;
            $display("FAIL both: bin=%0d pulses=%0d, expected bin=0 pulses=0", bin, pulses);
        end
        // Both debouncers must have returned to idle: a lone Up press still counts.
        press(1'b1, 1'b0, p);
        checks++;
        if (bin !== 4'd1 || p !== 1) begin
            errors++;
            $display("FAIL both_after: bin=%0d pulses=%0d, expected bin=1 pulses=1", bin, p);
        end
    endtask

    task automatic test_reset_mid();
        int p;
        logic [3:0] exp_bin;
        logic       exp_chg;
        do_reset();
        for (int n = 0; n < 7; n++) press(1'b1, 1'b0, p);
        checks++;
        if (bin !== 4'd7) begin
            errors++;
            $display("FAIL reset_mid setup: bin=%0d, expected 7", bin);
        end
        sw_up = 1'b1;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (bin !== 4'd0 || chg !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid clear: bin=%0d chg=%b, expected bin=0 chg=0", bin, chg);
        end
        for (int e = 5; e <= 14; e++) begin
            tick();
            exp_bin = (e >= 10) ? 4'd1 : 4'd0;
            exp_chg = (e == 10);
            checks++;
            if (bin !== exp_bin || chg !== exp_chg) begin
                errors++;
                $display("FAIL reset_mid edge %0d: bin=%0d chg=%b, expected bin=%0d chg=%b",
                         e, bin, chg, exp_bin, exp_chg);
            end
        end
        sw_up = 1'b0;
    endtask

    initial begin
        rst = 1'b1; sw_up = 1'b0; sw_dn = 1'b0;
        test_reset();
        test_first_press();
        test_down_wrap();
        test_up_wrap();
        test_glitch();
        test_both();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/debounce_nibble_counter.md
DEBOUNCE_NIBBLE_COUNTER -- requirements
Module: debounce_nibble_counter

Interface
REQ-001 Parameter DEBOUNCE_LIMIT, default 250000, is the number of consecutive clocks a synchronized switch level must hold before it is accepted (10 ms at 25 MHz); legal range is 2 or greater.
REQ-002 i_Clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 i_Reset  input  1  reset; synchronous and active-high.
REQ-004 i_Switch_Up  input  1  raw asynchronous push-button; 1 = pressed.
REQ-005 i_Switch_Down  input  1  raw asynchronous push-button; 1 = pressed.
REQ-006 o_Binary_Num  output  4  registered count value; feeds the 7-segment encoder nibble input.
REQ-007 o_Count_Change  output  1  registered one-cycle pulse, high in the cycle o_Binary_Num takes a new value.

Function
REQ-008 Each switch input shall pass through a two-flop synchronizer (sync1, sync2) before any other use.
REQ-009 Each switch shall have an independent debouncer holding a stable level and a counter of width $clog2(DEBOUNCE_LIMIT).
REQ-010 When sync2 equals the stable level, the debounce counter shall clear to 0.
REQ-011 When sync2 differs from the stable level and the counter is below DEBOUNCE_LIMIT-1, the counter shall increment by 1.
REQ-012 When sync2 differs from the stable level and the counter equals DEBOUNCE_LIMIT-1, the stable level shall take the sync2 value and the counter shall clear to 0.
REQ-013 A press event is a stable-level transition 0->1 per REQ-012; a 1->0 transition (release) shall produce no event.
REQ-014 For an input change first sampled by sync1 on edge 1, with the input held steady, the stable level shall flip on edge DEBOUNCE_LIMIT+2.
REQ-015 Any mismatch lasting fewer clocks than required by REQ-014 shall leave the stable level, count and outputs unchanged.
REQ-016 On the same edge as an Up press event alone, o_Binary_Num shall increment modulo 16 (15 -> 0) and o_Count_Change shall be 1.
REQ-017 On the same edge as a Down press event alone, o_Binary_Num shall decrement modulo 16 (0 -> 15) and o_Count_Change shall be 1.
REQ-018 If Up and Down press events occur on the same edge, o_Binary_Num shall hold and o_Count_Change shall be 0.
REQ-019 In every cycle without a qualifying event, o_Count_Change shall be 0 and o_Binary_Num shall hold.
REQ-020 Holding a switch pressed shall produce exactly one event; no auto-repeat.

Reset
REQ-021 While i_Reset is 1 at a rising edge, o_Binary_Num shall become 0, o_Count_Change 0, all synchronizer flops 0, stable levels 0 and debounce counters 0.
REQ-022 Reset asserted mid-debounce shall abandon the pending transition and produce no event.
REQ-023 A switch held pressed through reset release shall be debounced from stable level 0 and yield one press event DEBOUNCE_LIMIT+2 edges after release.

Verification (DEBOUNCE_LIMIT=4)
REQ-024 Reset, then i_Switch_Up 0->1 sampled on edge 1 and held -> o_Binary_Num 0->1 with o_Count_Change=1 on edge 6 only; release -> no further change.
REQ-025 From 0, one clean i_Switch_Down press -> o_Binary_Num=15 and a single pulse; 16 clean Up presses from 0 -> values 1..15 then 0, 16 pulses total.
REQ-026 i_Switch_Up glitch high for 3 clocks, then low -> o_Binary_Num unchanged and o_Count_Change never 1.
REQ-027 Both switches 0->1 on the same edge and held -> stable levels flip on edge 6, o_Binary_Num holds, o_Count_Change stays 0.
REQ-028 Count at 7, Up pressed, i_Reset pulsed on edge 4 -> o_Binary_Num=0 after reset, then exactly one increment to 1 six edges after reset release while Up is held.
